// File: rtl/dsp_wresp_arbiter_if.sv
// ---------------------------------------------------------------------------
// dsp_wresp_arbiter_if
//
// Purpose:
//   Bundles the write-response (B channel) signals around the dispatcher's
//   master-side WRESP arbiter. It carries the per-slave B channels in one
//   direction and the merged master B channel in the other.
//
// Signal summary (directions as seen by the arbiter):
//   sa_BID_i     in   TRANS_MST_ID_W*SLV_AMT   per-slave BID, slice s at
//                                             [TRANS_MST_ID_W*(s+1)-1 -: TRANS_MST_ID_W]
//   sa_BRESP_i   in   TRANS_WR_RESP_W*SLV_AMT  per-slave BRESP, same slicing
//   sa_BVALID_i  in   SLV_AMT                  per-slave response valid
//   sa_BREADY_o  out  SLV_AMT                  per-slave ready, one-hot or zero
//   m_BID_o      out  TRANS_MST_ID_W           registered BID to the master
//   m_BRESP_o    out  TRANS_WR_RESP_W          registered BRESP to the master
//   m_BVALID_o   out  1                        registered valid to the master
//   m_BREADY_i   in   1                        master ready
//   grant_slv_o  out  SLV_ID_W                 slave whose response is held
//
// Modports:
//   master : the arbiter itself (drives the *_o signals).
//   slave  : the surrounding logic (per-slave channels and master port).
// ---------------------------------------------------------------------------
interface dsp_wresp_arbiter_if #(
  parameter int SLV_AMT         = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2
);

  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_BID_i;
  logic [TRANS_WR_RESP_W*SLV_AMT-1:0] sa_BRESP_i;
  logic [SLV_AMT-1:0]                 sa_BVALID_i;
  logic [SLV_AMT-1:0]                 sa_BREADY_o;

  logic [TRANS_MST_ID_W-1:0]          m_BID_o;
  logic [TRANS_WR_RESP_W-1:0]         m_BRESP_o;
  logic                               m_BVALID_o;
  logic                               m_BREADY_i;

  logic [SLV_ID_W-1:0]                grant_slv_o;

  modport master (
    input  sa_BID_i,
    input  sa_BRESP_i,
    input  sa_BVALID_i,
    output sa_BREADY_o,
    output m_BID_o,
    output m_BRESP_o,
    output m_BVALID_o,
    input  m_BREADY_i,
    output grant_slv_o
  );

  modport slave (
    output sa_BID_i,
    output sa_BRESP_i,
    output sa_BVALID_i,
    input  sa_BREADY_o,
    input  m_BID_o,
    input  m_BRESP_o,
    input  m_BVALID_o,
    output m_BREADY_i,
    input  grant_slv_o
  );

endinterface

// File: rtl/dsp_wresp_arbiter.sv
// ---------------------------------------------------------------------------
// dsp_wresp_arbiter
//
// Purpose:
//   Master-side write-response arbiter of the dispatcher. It merges the B
//   channels of SLV_AMT slave-side WRESP channels onto a single master B
//   channel. A round-robin arbiter picks at most one response per cycle and
//   moves it into a one-entry registered output stage. The output stage can
//   drain and reload in the same cycle, so a stream of responses goes
//   through at one per cycle with no bubbles.
//
// Ports:
//   ACLK_i      in   1   clock, all state updates on the rising edge
//   ARESETn_i   in   1   synchronous active-low reset
//   wresp_if    --   dsp_wresp_arbiter_if.master
//                    (per-slave B channels, master B channel, grant index)
//   err_cnt_o   out  16  saturating count of master handshakes carrying
//                        SLVERR/DECERR (only with WRESP_ERR_CNT_EN)
//
// Configuration:
//   WRESP_ERR_CNT_EN : when defined, adds the error counter and err_cnt_o.
//                      When undefined, neither exists and all other
//                      behaviour is the same.
// ---------------------------------------------------------------------------
module dsp_wresp_arbiter #(
  parameter int SLV_AMT         = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2
) (
  input  logic                     ACLK_i,
  input  logic                     ARESETn_i,
  dsp_wresp_arbiter_if.master      wresp_if
`ifdef WRESP_ERR_CNT_EN
  ,
  output logic [15:0]              err_cnt_o
`endif
);

  // Output stage states: EMPTY holds nothing, FULL holds one response that
  // is being offered to the master.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [SLV_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SLV_ID_W-1:0]        grant_q, grant_d;
  logic [TRANS_MST_ID_W-1:0]  bid_q, bid_d;
  logic [TRANS_WR_RESP_W-1:0] bresp_q, bresp_d;

  logic [SLV_ID_W-1:0]        winner;
  logic [SLV_ID_W-1:0]        cand;
  logic                       found;
  logic                       req_any;
  logic                       load_en;
  logic                       slv_hs;
  logic                       mst_hs;
  logic [SLV_AMT-1:0]         bready;

  // Index base+off, wrapped into 0..SLV_AMT-1. off is below SLV_AMT and base
  // is always a legal index, so a single subtraction is enough.
  function automatic logic [SLV_ID_W-1:0] wrap_idx(
    input logic [SLV_ID_W-1:0] base,
    input int                  off
  );
    int sum;
    sum = int'(base) + off;
    if (sum >= SLV_AMT) begin
      sum = sum - SLV_AMT;
    end
    return SLV_ID_W'(sum);
  endfunction

  // Round-robin search: walk the valid vector starting at rr_ptr and keep
  // the first requester found. The winner only matters when req_any is set.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < SLV_AMT; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!found && wresp_if.sa_BVALID_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign req_any = |wresp_if.sa_BVALID_i;

  // The stage can accept a new response when it is empty, or when its
  // current response leaves towards the master in this same cycle.
  assign load_en = (state_q == ST_EMPTY) || wresp_if.m_BREADY_i;

  // Master handshake on the registered output.
  assign mst_hs = (state_q == ST_FULL) && wresp_if.m_BREADY_i;

  // A slave handshake always belongs to the winner, because the winner is
  // by construction a valid channel whenever any channel is valid. Reset
  // masks it so no slave sees a ready while the block is being cleared.
  assign slv_hs = ARESETn_i && load_en && req_any;

  // Ready goes only to the winner. It is not a function of the losers'
  // valids beyond their effect on who wins.
  always_comb begin
    bready = '0;
    if (slv_hs) begin
      bready[winner] = 1'b1;
    end
  end

  // Next-state logic for the output stage and round-robin pointer. A load
  // takes priority over a plain drain, which gives back-to-back transfers.
  // With the stage full and the master stalling, nothing moves.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (slv_hs) begin
      state_d  = ST_FULL;
      grant_d  = winner;
      bid_d    = wresp_if.sa_BID_i[int'(winner)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
      bresp_d  = wresp_if.sa_BRESP_i[int'(winner)*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
      rr_ptr_d = (int'(winner) == SLV_AMT-1) ? '0 : winner + 1'b1;
    end else if (mst_hs) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers with synchronous reset. Reset discards any buffered
  // response without a master handshake.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      bid_q    <= '0;
      bresp_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

`ifdef WRESP_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count each response delivered to the master whose BRESP upper bit is set
  // (SLVERR or DECERR). The counter sticks at all-ones instead of wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mst_hs && bresp_q[TRANS_WR_RESP_W-1] && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register, cleared by reset.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign wresp_if.sa_BREADY_o = bready;
  assign wresp_if.m_BID_o     = bid_q;
  assign wresp_if.m_BRESP_o   = bresp_q;
  assign wresp_if.m_BVALID_o  = (state_q == ST_FULL);
  assign wresp_if.grant_slv_o = grant_q;

endmodule

// File: tb/tb_dsp_wresp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dsp_wresp_arbiter
//
// Bench for the master-side write-response arbiter (two slave channels).
// Directed steps walk through reset, a single response, round-robin,
// backpressure and a reset in the middle of a transfer. A randomized phase
// follows. Every step is also predicted by a small reference model that
// works at transaction level: "who gets served next" and "what does the
// master currently hold".
// ---------------------------------------------------------------------------
module tb_dsp_wresp_arbiter;

  localparam int SLV_AMT  = 2;
  localparam int SLV_ID_W = 1;
  localparam int ID_W     = 5;
  localparam int RESP_W   = 2;

  logic clk = 1'b0;
  logic rstn;

  dsp_wresp_arbiter_if #(
    .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W),
    .TRANS_MST_ID_W(ID_W), .TRANS_WR_RESP_W(RESP_W)
  ) bus ();

`ifdef WRESP_ERR_CNT_EN
  logic [15:0] errCnt;
`endif

  dsp_wresp_arbiter #(
    .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W),
    .TRANS_MST_ID_W(ID_W), .TRANS_WR_RESP_W(RESP_W)
  ) dut (
    .ACLK_i    (clk),
    .ARESETn_i (rstn),
    .wresp_if  (bus)
`ifdef WRESP_ERR_CNT_EN
    ,
    .err_cnt_o (errCnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: what the master side is holding, and which slave the
  // round-robin will look at first.
  bit         mdlValid;
  logic [4:0] mdlId;
  logic [1:0] mdlResp;
  int         mdlGrant;
  int         mdlNext;
  int         mdlErr;
  logic [1:0] lastReady;

  // One comparison: count it, and report it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requesting slave when scanning from mdlNext upward with wrap.
  function automatic int pickWinner(input logic [1:0] v);
    for (int k = 0; k < SLV_AMT; k++) begin
      if (v[(mdlNext + k) % SLV_AMT]) return (mdlNext + k) % SLV_AMT;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, check the combinational ready, clock it in,
  // advance the model and check the registered outputs.
  task automatic applyStimulus(input bit r, input logic [1:0] v,
                               input logic [4:0] id0, input logic [4:0] id1,
                               input logic [1:0] rs0, input logic [1:0] rs1,
                               input bit mr, input string tag);
    int         w;
    bit         canTake;
    logic [1:0] expReady;
    rstn            = r;
    bus.sa_BVALID_i = v;
    bus.sa_BID_i    = {id1, id0};
    bus.sa_BRESP_i  = {rs1, rs0};
    bus.m_BREADY_i  = mr;
    #1;
    canTake  = !mdlValid || mr;
    w        = pickWinner(v);
    expReady = 2'b00;
    if (r && canTake && (w >= 0)) expReady[w] = 1'b1;
    lastReady = bus.sa_BREADY_o;
    checkOutput({tag, ".ready"}, 32'(bus.sa_BREADY_o), 32'(expReady));
    @(posedge clk);
    if (!r) begin
      mdlValid = 1'b0; mdlId = '0; mdlResp = '0;
      mdlGrant = 0;    mdlNext = 0; mdlErr = 0;
    end else begin
      if (mdlValid && mr && mdlResp[1] && (mdlErr < 65535)) mdlErr++;
      if (expReady != 2'b00) begin
        mdlValid = 1'b1;
        mdlId    = (w == 0) ? id0 : id1;
        mdlResp  = (w == 0) ? rs0 : rs1;
        mdlGrant = w;
        mdlNext  = (w + 1) % SLV_AMT;
      end else if (mdlValid && mr) begin
        mdlValid = 1'b0;
      end
    end
    #1;
    checkOutput({tag, ".valid"}, 32'(bus.m_BVALID_o),  32'(mdlValid));
    checkOutput({tag, ".bid"},   32'(bus.m_BID_o),     32'(mdlId));
    checkOutput({tag, ".bresp"}, 32'(bus.m_BRESP_o),   32'(mdlResp));
    checkOutput({tag, ".grant"}, 32'(bus.grant_slv_o), 32'(mdlGrant));
`ifdef WRESP_ERR_CNT_EN
    checkOutput({tag, ".errcnt"}, 32'(errCnt), 32'(mdlErr));
`endif
  endtask

  initial begin
    rstn            = 1'b0;
    bus.sa_BVALID_i = '0;
    bus.sa_BID_i    = '0;
    bus.sa_BRESP_i  = '0;
    bus.m_BREADY_i  = 1'b0;
    mdlValid = 1'b0; mdlId = '0; mdlResp = '0;
    mdlGrant = 0;    mdlNext = 0; mdlErr = 0;
    lastReady = '0;
    #2;

    // Reset held for two cycles, with requests present to show ready masked.
    applyStimulus(1'b0, 2'b11, 5'h01, 5'h02, 2'b00, 2'b00, 1'b1, "rst0");
    applyStimulus(1'b0, 2'b11, 5'h01, 5'h02, 2'b00, 2'b00, 1'b1, "rst1");
    checkOutput("rst.readyForced", 32'(lastReady), 32'h0);

    // Idle after reset.
    applyStimulus(1'b1, 2'b00, 5'h00, 5'h00, 2'b00, 2'b00, 1'b1, "idle");
    checkOutput("idle.valid", 32'(bus.m_BVALID_o), 32'h0);
    checkOutput("idle.ready", 32'(lastReady),      32'h0);
    checkOutput("idle.grant", 32'(bus.grant_slv_o), 32'h0);

    // Single response from slave 1.
    applyStimulus(1'b1, 2'b10, 5'h00, 5'h13, 2'b00, 2'b00, 1'b1, "single");
    checkOutput("single.ready", 32'(lastReady),       32'h2);
    checkOutput("single.bid",   32'(bus.m_BID_o),     32'h13);
    checkOutput("single.valid", 32'(bus.m_BVALID_o),  32'h1);
    checkOutput("single.grant", 32'(bus.grant_slv_o), 32'h1);
    applyStimulus(1'b1, 2'b00, 5'h00, 5'h00, 2'b00, 2'b00, 1'b1, "drain");
    checkOutput("drain.valid", 32'(bus.m_BVALID_o), 32'h0);

    // Round-robin with both slaves requesting on every cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b11, 5'h01, 5'h02, 2'b00, 2'b00, 1'b1, "rr");
      checkOutput("rr.seq",   32'(bus.m_BID_o),    (i % 2 == 0) ? 32'h01 : 32'h02);
      checkOutput("rr.noGap", 32'(bus.m_BVALID_o), 32'h1);
    end

    // Backpressure: load 0A, stall four cycles, then release.
    applyStimulus(1'b1, 2'b01, 5'h0A, 5'h00, 2'b00, 2'b00, 1'b1, "bpLoad");
    checkOutput("bpLoad.bid", 32'(bus.m_BID_o), 32'h0A);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b01, 5'h0B, 5'h00, 2'b00, 2'b00, 1'b0, "bpStall");
      checkOutput("bpStall.ready", 32'(lastReady),   32'h0);
      checkOutput("bpStall.bid",   32'(bus.m_BID_o), 32'h0A);
    end
    applyStimulus(1'b1, 2'b01, 5'h0B, 5'h00, 2'b00, 2'b00, 1'b1, "bpRelease");
    checkOutput("bpRelease.ready", 32'(lastReady),   32'h1);
    checkOutput("bpRelease.bid",   32'(bus.m_BID_o), 32'h0B);

    // Reset while the master stalls on a held response; the pointer was
    // past slave 0, so the first grant afterwards shows it was cleared.
    applyStimulus(1'b0, 2'b11, 5'h04, 5'h05, 2'b00, 2'b00, 1'b0, "midRst");
    checkOutput("midRst.valid", 32'(bus.m_BVALID_o), 32'h0);
    checkOutput("midRst.grant", 32'(bus.grant_slv_o), 32'h0);
    applyStimulus(1'b1, 2'b11, 5'h04, 5'h05, 2'b00, 2'b00, 1'b1, "postRst");
    checkOutput("postRst.ptrZero", 32'(lastReady), 32'h1);

`ifdef WRESP_ERR_CNT_EN
    // Three responses with BRESP 10, 00, 11, each delivered to the master.
    applyStimulus(1'b0, 2'b00, 5'h00, 5'h00, 2'b00, 2'b00, 1'b1, "errRst");
    applyStimulus(1'b1, 2'b01, 5'h03, 5'h00, 2'b10, 2'b00, 1'b1, "err0");
    applyStimulus(1'b1, 2'b01, 5'h04, 5'h00, 2'b00, 2'b00, 1'b1, "err1");
    applyStimulus(1'b1, 2'b01, 5'h05, 5'h00, 2'b11, 2'b00, 1'b1, "err2");
    applyStimulus(1'b1, 2'b00, 5'h00, 5'h00, 2'b00, 2'b00, 1'b1, "errDrain");
    checkOutput("err.count", 32'(errCnt), 32'd2);
`endif

    // Randomized traffic with occasional resets and master stalls.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    2'($urandom_range(0, 3)),
                    5'($urandom), 5'($urandom),
                    2'($urandom), 2'($urandom),
                    ($urandom_range(0, 3) != 0),
                    "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
